// File: rtl/arya_pkt_pkg.sv
// -----------------------------------------------------------------------------
// arya_pkt_pkg
//
// Shared definitions for the packet ingress/egress steering blocks.
//   disp_state_t  : dispatcher FSM encodings (idle, header run, payload run)
//   CTRL_DATA     : ctrl byte value that marks a plain payload word
//   thread_idx_w  : index width for a given thread count (never below 1 bit)
//   THREAD_IDX_W  : index width for the default eight-thread configuration
// -----------------------------------------------------------------------------
package arya_pkt_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHdr     = 2'd1,
        StPayload = 2'd2
    } disp_state_t;

    localparam logic [7:0] CTRL_DATA = 8'h00;

    localparam int unsigned NUM_THREADS_DEFAULT = 8;

    // A single-thread build still needs a 1-bit index to declare vectors.
    function automatic int unsigned thread_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned THREAD_IDX_W = thread_idx_w(NUM_THREADS_DEFAULT);

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//
// Combinational round-robin find-first. Returns the first set bit of
// free_mask at or above ptr, wrapping modulo NUM.
//   free_mask : NUM-bit mask of candidates (1 = selectable)
//   ptr       : starting index, must be < NUM
//   sel       : selected index (0 when nothing is selectable)
//   valid     : at least one candidate exists
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [NUM-1:0]   free_mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    // base + off folded back into 0..NUM-1; both operands are < NUM.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM) begin
            s = s - NUM;
        end
        return s[IDX_W-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        sel   = '0;
        valid = |free_mask;
        for (int i = int'(NUM) - 1; i >= 0; i--) begin
            if (free_mask[wrap_add(ptr, unsigned'(i))]) begin
                sel = wrap_add(ptr, unsigned'(i));
            end
        end
    end

endmodule

// File: rtl/infifo_dispatcher.sv
// -----------------------------------------------------------------------------
// infifo_dispatcher
//
// Steers each complete inbound packet into one free thread input FIFO,
// choosing threads round-robin, and pulses that thread's start line once the
// last word has been written. A thread stays claimed until it releases itself.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   in_data/in_ctrl : inbound word and ctrl byte (ctrl != 0: header or last)
//   in_wr           : word valid, legal only while in_rdy is high
//   in_rdy          : registered accept-ready
//   df_in_data/ctrl : registered copy of the accepted word, to all threads
//   df_in_wr        : one-hot write strobe to the thread being filled
//   thread_start    : one-cycle pulse, packet complete in that thread
//   thread_release  : one-cycle pulse per thread, thread is free again
//   thread_claimed  : per-thread ownership status
//   overflow_err    : one-cycle pulse, word offered while not ready (dropped)
// -----------------------------------------------------------------------------
module infifo_dispatcher
    import arya_pkt_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            in_data,
    input  logic [7:0]             in_ctrl,
    input  logic                   in_wr,
    output logic                   in_rdy,
    output logic [63:0]            df_in_data,
    output logic [7:0]             df_in_ctrl,
    output logic [NUM_THREADS-1:0] df_in_wr,
    output logic [NUM_THREADS-1:0] thread_start,
    input  logic [NUM_THREADS-1:0] thread_release,
    output logic [NUM_THREADS-1:0] thread_claimed,
    output logic                   overflow_err
);

    localparam int unsigned IDX_W = thread_idx_w(NUM_THREADS);

    disp_state_t            state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       cur;
    // Set on the edge that accepts a last word; turns the following
    // df_in_wr strobe into the start pulse.
    logic                   last_q;

    logic                   accept;
    logic [IDX_W-1:0]       pick_sel;
    logic                   pick_valid;
    logic [NUM_THREADS-1:0] rel_mask;
    logic [NUM_THREADS-1:0] claim_set;

    function automatic logic [NUM_THREADS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_THREADS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = in_wr & in_rdy;

    rr_picker #(
        .NUM   (NUM_THREADS),
        .IDX_W (IDX_W)
    ) u_picker (
        .free_mask (~thread_claimed),
        .ptr       (ptr),
        .sel       (pick_sel),
        .valid     (pick_valid)
    );

    // The thread being filled cannot be released out from under the packet.
    always_comb begin
        rel_mask = thread_release;
        if (state != StIdle) begin
            rel_mask[cur] = 1'b0;
        end
    end

    // Only unclaimed threads are picked, so a claim never collides with a
    // release of the same index on one edge.
    always_comb begin
        claim_set = '0;
        if (state == StIdle && pick_valid) begin
            claim_set = onehot(pick_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            ptr            <= '0;
            cur            <= '0;
            last_q         <= 1'b0;
            in_rdy         <= 1'b0;
            df_in_data     <= '0;
            df_in_ctrl     <= '0;
            df_in_wr       <= '0;
            thread_start   <= '0;
            thread_claimed <= '0;
            overflow_err   <= 1'b0;
        end else begin
            df_in_wr       <= '0;
            last_q         <= 1'b0;
            overflow_err   <= in_wr & ~in_rdy;
            thread_start   <= last_q ? df_in_wr : '0;
            thread_claimed <= (thread_claimed & ~rel_mask) | claim_set;

            if (accept) begin
                df_in_data <= in_data;
                df_in_ctrl <= in_ctrl;
                df_in_wr   <= onehot(cur);
            end

            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        cur    <= pick_sel;
                        in_rdy <= 1'b1;
                        state  <= StHdr;
                    end
                end
                StHdr: begin
                    if (accept && in_ctrl == CTRL_DATA) begin
                        state <= StPayload;
                    end
                end
                StPayload: begin
                    if (accept && in_ctrl != CTRL_DATA) begin
                        in_rdy <= 1'b0;
                        last_q <= 1'b1;
                        state  <= StIdle;
                        if (32'(cur) == NUM_THREADS - 1) begin
                            ptr <= '0;
                        end else begin
                            ptr <= cur + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    in_rdy <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_infifo_dispatcher.sv
module tb_infifo_dispatcher;

    localparam int unsigned NT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   in_data;
    logic [7:0]    in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [63:0]   df_in_data;
    logic [7:0]    df_in_ctrl;
    logic [NT-1:0] df_in_wr;
    logic [NT-1:0] thread_start;
    logic [NT-1:0] thread_release;
    logic [NT-1:0] thread_claimed;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;
    int pkt_id = 0;
    logic [63:0] last_word;

    infifo_dispatcher #(
        .NUM_THREADS (NT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .in_wr          (in_wr),
        .in_rdy         (in_rdy),
        .df_in_data     (df_in_data),
        .df_in_ctrl     (df_in_ctrl),
        .df_in_wr       (df_in_wr),
        .thread_start   (thread_start),
        .thread_release (thread_release),
        .thread_claimed (thread_claimed),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input int thr);
        int waited;
        logic [NT-1:0] exp_wr;
        waited = 0;
        while (!in_rdy && waited < 16) begin
            tick();
            waited++;
        end
        if (!in_rdy) begin
            check_val("rdy_timeout", 64'(in_rdy), 64'd1);
            return;
        end
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        tick();
        in_wr   = 1'b0;
        exp_wr  = '0;
        exp_wr[thr] = 1'b1;
        check_val("df_in_wr", 64'(df_in_wr), 64'(exp_wr));
        check_val("df_in_data", df_in_data, d);
        check_val("df_in_ctrl", 64'(df_in_ctrl), 64'(c));
    endtask

    // One header, one payload, one last word.
    task automatic send_pkt(input int thr);
        logic [63:0] base;
        pkt_id++;
        base = 64'hA500_0000_0000_0000 | (64'(pkt_id) << 8);
        send_word(base | 64'd1, 8'hFF, thr);
        send_word(base | 64'd2, 8'h00, thr);
        send_word(base | 64'd3, 8'h0F, thr);
        last_word = base | 64'd3;
    endtask

    initial begin
        reset          = 1'b1;
        in_wr          = 1'b0;
        in_data        = '0;
        in_ctrl        = '0;
        thread_release = '0;
        tick();
        tick();
        check_val("rst_in_rdy", 64'(in_rdy), 64'd0);
        check_val("rst_df_in_wr", 64'(df_in_wr), 64'd0);
        check_val("rst_claimed", 64'(thread_claimed), 64'd0);
        check_val("rst_start", 64'(thread_start), 64'd0);
        check_val("rst_overflow", 64'(overflow_err), 64'd0);
        check_val("rst_df_in_data", df_in_data, 64'd0);
        reset = 1'b0;

        // Single packet: 2 headers, 3 payload words, last word.
        tick();
        check_val("idle_to_hdr_rdy", 64'(in_rdy), 64'd1);
        check_val("idle_claim0", 64'(thread_claimed), 64'h01);
        send_word(64'h1111, 8'hFF, 0);
        send_word(64'h2222, 8'h01, 0);
        send_word(64'h3333, 8'h00, 0);
        send_word(64'h4444, 8'h00, 0);
        send_word(64'h5555, 8'h00, 0);
        send_word(64'h6666, 8'h0F, 0);
        check_val("last_rdy_low", 64'(in_rdy), 64'd0);
        check_val("last_claimed", 64'(thread_claimed), 64'h01);
        check_val("start_early", 64'(thread_start), 64'd0);
        tick();
        check_val("start_pulse", 64'(thread_start), 64'h01);
        check_val("gap_rdy", 64'(in_rdy), 64'd1);
        check_val("next_claim", 64'(thread_claimed), 64'h03);
        tick();
        check_val("start_clear", 64'(thread_start), 64'd0);

        // Eight back-to-back packets fill every thread in order.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < int'(NT); p++) begin
            send_pkt(p);
        end
        tick();
        tick();
        tick();
        check_val("full_rdy", 64'(in_rdy), 64'd0);
        check_val("full_claimed", 64'(thread_claimed), 64'hFF);

        // Word offered while not ready is dropped.
        in_data = 64'hDEAD_BEEF;
        in_ctrl = 8'hFF;
        in_wr   = 1'b1;
        tick();
        in_wr   = 1'b0;
        check_val("ovf_pulse", 64'(overflow_err), 64'd1);
        check_val("ovf_no_wr", 64'(df_in_wr), 64'd0);
        check_val("ovf_data_kept", df_in_data, last_word);
        tick();
        check_val("ovf_once", 64'(overflow_err), 64'd0);
        check_val("ovf_rdy", 64'(in_rdy), 64'd0);
        check_val("ovf_claimed", 64'(thread_claimed), 64'hFF);

        // Release thread 3; it is reusable on the following edge.
        thread_release = 8'h08;
        tick();
        thread_release = '0;
        check_val("rel3_claimed", 64'(thread_claimed), 64'hF7);
        check_val("rel3_rdy", 64'(in_rdy), 64'd0);
        tick();
        check_val("reuse3_rdy", 64'(in_rdy), 64'd1);
        check_val("reuse3_claimed", 64'(thread_claimed), 64'hFF);
        send_pkt(3);

        // Bring ptr to 6 with all threads claimed.
        thread_release = 8'h30;
        tick();
        thread_release = '0;
        send_pkt(4);
        send_pkt(5);
        tick();
        tick();
        check_val("ptr6_rdy", 64'(in_rdy), 64'd0);
        check_val("ptr6_claimed", 64'(thread_claimed), 64'hFF);

        // Free 0..5 at once; 6 and 7 stay claimed so the pick wraps to 0.
        thread_release = 8'h3F;
        tick();
        thread_release = '0;
        check_val("multi_release", 64'(thread_claimed), 64'hC0);
        tick();
        check_val("wrap_claim", 64'(thread_claimed), 64'hC1);
        send_pkt(0);
        send_pkt(1);

        // Reset mid-payload on thread 2.
        send_word(64'h7777, 8'hFF, 2);
        send_word(64'h8888, 8'h00, 2);
        reset = 1'b1;
        tick();
        check_val("mid_rst_rdy", 64'(in_rdy), 64'd0);
        check_val("mid_rst_wr", 64'(df_in_wr), 64'd0);
        check_val("mid_rst_claimed", 64'(thread_claimed), 64'd0);
        check_val("mid_rst_data", df_in_data, 64'd0);
        check_val("mid_rst_ctrl", 64'(df_in_ctrl), 64'd0);
        check_val("mid_rst_start", 64'(thread_start), 64'd0);
        reset = 1'b0;
        send_pkt(0);

        // Self-release of the thread being filled is ignored.
        send_word(64'h9999, 8'hFF, 1);
        send_word(64'hAAAA, 8'h00, 1);
        thread_release = 8'h02;
        tick();
        thread_release = '0;
        check_val("self_rel_ignored", 64'(thread_claimed), 64'h03);
        send_word(64'hBBBB, 8'h0F, 1);
        tick();
        check_val("self_rel_start", 64'(thread_start), 64'h02);
        check_val("self_rel_claimed", 64'(thread_claimed), 64'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
